// File: rtl/dispatch_scheduler.sv
// Kernel block dispatcher: splits a launched kernel into fixed-size thread blocks
// and hands them to free compute cores in ascending order until every block has finished.
module dispatch_scheduler #(
   parameter int NUM_CORES         = 2,
   parameter int THREADS_PER_BLOCK = 4,
   parameter int THREAD_COUNT_BITS = 8
) (
   input  logic                                                     clk,
   input  logic                                                     reset,
   input  logic                                                     start,
   input  logic [THREAD_COUNT_BITS-1:0]                             thread_count,
   input  logic [NUM_CORES-1:0]                                     core_done,
   output logic [NUM_CORES-1:0]                                     core_reset,
   output logic [NUM_CORES-1:0]                                     core_start,
   output logic [NUM_CORES-1:0][THREAD_COUNT_BITS-1:0]              core_block_id,
   output logic [NUM_CORES-1:0][$clog2(THREADS_PER_BLOCK):0]        core_thread_count,
   output logic                                                     done
);

   localparam int SHIFT = $clog2(THREADS_PER_BLOCK);
   localparam int CTW   = SHIFT + 1;
   localparam int CW    = THREAD_COUNT_BITS + 1;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_DISPATCH = 2'd1,
      S_DONE     = 2'd2
   } top_state_t;

   typedef enum logic [1:0] {
      C_FREE     = 2'd0,
      C_CLEARING = 2'd1,
      C_RUNNING  = 2'd2
   } core_state_t;

   top_state_t               state_r;
   core_state_t              core_state_r [NUM_CORES];
   logic [SHIFT-1:0]         rem_r;
   logic [CW-1:0]            total_blocks_r;
   logic [CW-1:0]            blocks_dispatched_r;
   logic [CW-1:0]            blocks_done_r;

   logic [NUM_CORES-1:0]         grant_s;
   logic [NUM_CORES-1:0]         finish_s;
   logic [THREAD_COUNT_BITS-1:0] grant_id_s  [NUM_CORES];
   logic [CTW-1:0]               grant_cnt_s [NUM_CORES];
   logic [CW-1:0]                next_dispatched_s;
   logic [CW-1:0]                done_count_s;
   logic [CW-1:0]                launch_blocks_s;

   // Block grants (lower cores first) and completion count for the current cycle
   always_comb begin
      next_dispatched_s = blocks_dispatched_r;
      done_count_s      = '0;
      grant_s           = '0;
      finish_s          = '0;
      launch_blocks_s   = ({1'b0, thread_count} + CW'(THREADS_PER_BLOCK - 1)) >> SHIFT;
      for (int i = 0; i < NUM_CORES; i++) begin
         grant_id_s[i] = next_dispatched_s[THREAD_COUNT_BITS-1:0];
         // Only a short final block carries the remainder count
         if (({1'b0, grant_id_s[i]} == (total_blocks_r - CW'(1))) && (rem_r != '0)) begin
            grant_cnt_s[i] = {1'b0, rem_r};
         end else begin
            grant_cnt_s[i] = CTW'(THREADS_PER_BLOCK);
         end
         if ((state_r == S_DISPATCH) && (core_state_r[i] == C_FREE) &&
             (next_dispatched_s < total_blocks_r)) begin
            grant_s[i]        = 1'b1;
            next_dispatched_s = next_dispatched_s + CW'(1);
         end else begin
            grant_s[i] = 1'b0;
         end
         if ((state_r == S_DISPATCH) && (core_state_r[i] == C_RUNNING) && core_done[i]) begin
            finish_s[i]  = 1'b1;
            done_count_s = done_count_s + CW'(1);
         end else begin
            finish_s[i] = 1'b0;
         end
      end
   end

   // Top-level FSM, per-core state machines and all registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r             <= S_IDLE;
         rem_r               <= '0;
         total_blocks_r      <= '0;
         blocks_dispatched_r <= '0;
         blocks_done_r       <= '0;
         done                <= 1'b0;
         core_reset          <= '0;
         core_start          <= '0;
         core_block_id       <= '0;
         core_thread_count   <= '0;
         for (int i = 0; i < NUM_CORES; i++) begin
            core_state_r[i] <= C_FREE;
         end
      end else begin
         case (state_r)
            S_IDLE: begin
               if (start) begin
                  rem_r               <= thread_count[SHIFT-1:0];
                  total_blocks_r      <= launch_blocks_s;
                  blocks_dispatched_r <= '0;
                  blocks_done_r       <= '0;
                  done                <= 1'b0;
                  state_r             <= S_DISPATCH;
                  for (int i = 0; i < NUM_CORES; i++) begin
                     core_state_r[i] <= C_FREE;
                  end
               end
            end
            S_DISPATCH: begin
               if (blocks_done_r == total_blocks_r) begin
                  state_r <= S_DONE;
                  done    <= 1'b1;
               end else begin
                  blocks_dispatched_r <= next_dispatched_s;
                  blocks_done_r       <= blocks_done_r + done_count_s;
                  for (int i = 0; i < NUM_CORES; i++) begin
                     case (core_state_r[i])
                        C_FREE: begin
                           if (grant_s[i]) begin
                              core_state_r[i]      <= C_CLEARING;
                              core_reset[i]        <= 1'b1;
                              core_block_id[i]     <= grant_id_s[i];
                              core_thread_count[i] <= grant_cnt_s[i];
                           end
                        end
                        C_CLEARING: begin
                           core_state_r[i] <= C_RUNNING;
                           core_reset[i]   <= 1'b0;
                           core_start[i]   <= 1'b1;
                        end
                        C_RUNNING: begin
                           if (finish_s[i]) begin
                              core_state_r[i] <= C_FREE;
                              core_start[i]   <= 1'b0;
                           end
                        end
                        default: begin
                           core_state_r[i] <= C_FREE;
                           core_reset[i]   <= 1'b0;
                           core_start[i]   <= 1'b0;
                        end
                     endcase
                  end
               end
            end
            S_DONE: begin
               if (!start) begin
                  state_r <= S_IDLE;
                  done    <= 1'b0;
               end
            end
            default: begin
               state_r <= S_IDLE;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dispatch_scheduler.sv
// Randomised bench for dispatch_scheduler: a cycle-level reference model of the
// block-dispatch rules predicts every output after each rising edge.
module tb_dispatch_scheduler;

   localparam int NC  = 2;
   localparam int TPB = 4;
   localparam int TCB = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                    reset;
   logic                    start;
   logic [TCB-1:0]          thread_count;
   logic [NC-1:0]           core_done;
   logic [NC-1:0]           core_reset;
   logic [NC-1:0]           core_start;
   logic [NC-1:0][TCB-1:0]  core_block_id;
   logic [NC-1:0][2:0]      core_thread_count;
   logic                    done;

   dispatch_scheduler #(
      .NUM_CORES(NC),
      .THREADS_PER_BLOCK(TPB),
      .THREAD_COUNT_BITS(TCB)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .thread_count(thread_count),
      .core_done(core_done),
      .core_reset(core_reset),
      .core_start(core_start),
      .core_block_id(core_block_id),
      .core_thread_count(core_thread_count),
      .done(done)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: phase 0 = free, 1 = being cleared, 2 = running a block
   int m_top;
   int m_tc;
   int m_total;
   int m_next;
   int m_finished;
   int m_done;
   int m_phase [NC];
   int m_id    [NC];
   int m_cnt   [NC];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_step(input logic r, input logic s, input logic [TCB-1:0] t,
                             input logic [NC-1:0] cd);
      if (r) begin
         m_top = 0; m_tc = 0; m_total = 0; m_next = 0; m_finished = 0; m_done = 0;
         for (int c = 0; c < NC; c++) begin
            m_phase[c] = 0; m_id[c] = 0; m_cnt[c] = 0;
         end
      end else if (m_top == 0) begin
         if (s) begin
            m_tc       = int'(t);
            m_total    = (m_tc + TPB - 1) / TPB;
            m_next     = 0;
            m_finished = 0;
            m_top      = 1;
            for (int c = 0; c < NC; c++) m_phase[c] = 0;
         end
      end else if (m_top == 1) begin
         if (m_finished == m_total) begin
            m_top  = 2;
            m_done = 1;
         end else begin
            for (int c = 0; c < NC; c++) begin
               if (m_phase[c] == 0) begin
                  if (m_next < m_total) begin
                     m_phase[c] = 1;
                     m_id[c]    = m_next;
                     m_cnt[c]   = (m_tc - TPB * m_next > TPB) ? TPB : m_tc - TPB * m_next;
                     m_next++;
                  end
               end else if (m_phase[c] == 1) begin
                  m_phase[c] = 2;
               end else if (cd[c]) begin
                  m_phase[c] = 0;
                  m_finished++;
               end
            end
         end
      end else begin
         if (!s) begin
            m_top  = 0;
            m_done = 0;
         end
      end
   endtask

   task automatic check_outputs();
      for (int c = 0; c < NC; c++) begin
         chk($sformatf("core_reset[%0d]", c), 32'(core_reset[c]), (m_phase[c] == 1) ? 32'd1 : 32'd0);
         chk($sformatf("core_start[%0d]", c), 32'(core_start[c]), (m_phase[c] == 2) ? 32'd1 : 32'd0);
         chk($sformatf("core_block_id[%0d]", c), 32'(core_block_id[c]), 32'(m_id[c]));
         chk($sformatf("core_thread_count[%0d]", c), 32'(core_thread_count[c]), 32'(m_cnt[c]));
      end
      chk("done", 32'(done), 32'(m_done));
   endtask

   task automatic cycle(input logic r, input logic s, input logic [TCB-1:0] t,
                        input logic [NC-1:0] cd);
      reset = r; start = s; thread_count = t; core_done = cd;
      @(posedge clk);
      model_step(r, s, t, cd);
      #1;
      check_outputs();
   endtask

   function automatic logic [NC-1:0] run_mask();
      logic [NC-1:0] m;
      for (int c = 0; c < NC; c++) m[c] = (m_phase[c] == 2);
      return m;
   endfunction

   // 0: random finishes plus stray pulses, 1: all running cores together, 2: core 1 first
   function automatic logic [NC-1:0] cd_for(input int policy);
      logic [NC-1:0] rm;
      logic [NC-1:0] cd;
      rm = run_mask();
      cd = '0;
      case (policy)
         0: for (int c = 0; c < NC; c++)
               cd[c] = rm[c] ? ($urandom_range(2) == 0) : ($urandom_range(7) == 0);
         1: cd = rm;
         2: cd = rm[1] ? 2'b10 : rm;
         default: cd = '0;
      endcase
      return cd;
   endfunction

   task automatic run_kernel(input logic [TCB-1:0] tc, input int policy);
      int n;
      cycle(1'b0, 1'b1, tc, 2'b00);
      n = 0;
      while (m_top == 1 && n < 3000) begin
         cycle(1'b0, 1'($urandom_range(1)), 8'($urandom), cd_for(policy));
         n++;
      end
      chk("kernel_timeout", 32'(n < 3000), 32'd1);
      cycle(1'b0, 1'b1, 8'($urandom), 2'b00);
      cycle(1'b0, 1'b1, 8'($urandom), 2'b00);
      chk("done_held", 32'(done), 32'd1);
      cycle(1'b0, 1'b0, 8'($urandom), 2'b00);
      chk("done_cleared", 32'(done), 32'd0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; thread_count = '0; core_done = '0;
      cycle(1'b1, 1'b0, 8'd0, 2'b00);
      cycle(1'b1, 1'b1, 8'd8, 2'b11);
      chk("reset_outputs", 32'({core_reset, core_start, done}), 32'd0);
      repeat (4) cycle(1'b0, 1'b0, 8'($urandom), 2'($urandom));

      // Eight threads: both cores cleared together, then both finish together
      cycle(1'b0, 1'b1, 8'd8, 2'b00);
      cycle(1'b0, 1'b0, 8'd0, 2'b00);
      chk("k8_reset_pair", 32'(core_reset), 32'd3);
      chk("k8_id1", 32'(core_block_id[1]), 32'd1);
      chk("k8_cnt0", 32'(core_thread_count[0]), 32'd4);
      cycle(1'b0, 1'b0, 8'd0, 2'b00);
      chk("k8_start_pair", 32'(core_start), 32'd3);
      cycle(1'b0, 1'b0, 8'd0, 2'b11);
      chk("k8_not_done_yet", 32'(done), 32'd0);
      cycle(1'b0, 1'b0, 8'd0, 2'b00);
      chk("k8_done", 32'(done), 32'd1);
      cycle(1'b0, 1'b0, 8'd0, 2'b00);

      // Zero threads: straight to done without touching the cores
      cycle(1'b0, 1'b1, 8'd0, 2'b00);
      chk("k0_not_done_yet", 32'(done), 32'd0);
      cycle(1'b0, 1'b1, 8'd0, 2'b00);
      chk("k0_done", 32'(done), 32'd1);
      chk("k0_no_core_activity", 32'({core_reset, core_start}), 32'd0);
      cycle(1'b0, 1'b0, 8'd0, 2'b00);

      run_kernel(8'd10, 2);
      chk("k10_core1_last_id", 32'(core_block_id[1]), 32'd2);
      chk("k10_core1_last_cnt", 32'(core_thread_count[1]), 32'd2);
      chk("k10_core0_cnt", 32'(core_thread_count[0]), 32'd4);

      run_kernel(8'd16, 1);
      run_kernel(8'd255, 0);
      chk("k255_last_block",
          32'(((core_block_id[0] == 8'd63) && (core_thread_count[0] == 3'd3)) ||
              ((core_block_id[1] == 8'd63) && (core_thread_count[1] == 3'd3))), 32'd1);

      // Reset in the middle of a kernel with both cores running
      cycle(1'b0, 1'b1, 8'd40, 2'b00);
      cycle(1'b0, 1'b0, 8'd0, 2'b00);
      cycle(1'b0, 1'b0, 8'd0, 2'b00);
      chk("mid_both_running", 32'(core_start), 32'd3);
      cycle(1'b1, 1'b1, 8'd40, 2'b11);
      chk("mid_reset_outputs", 32'({core_reset, core_start, done}), 32'd0);
      chk("mid_reset_ids", 32'(core_block_id), 32'd0);
      cycle(1'b0, 1'b0, 8'd0, 2'b11);
      run_kernel(8'd12, 0);

      for (int k = 0; k < 6; k++) begin
         run_kernel(8'($urandom), int'($urandom_range(2)));
         repeat (2) cycle(1'b0, 1'b0, 8'($urandom), 2'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/dispatch_scheduler.md
DISPATCH_SCHEDULER -- requirements
Module: dispatch_scheduler

Interface
REQ-001 SHALL have parameter NUM_CORES, default 2, number of compute cores scheduled.
REQ-002 SHALL have parameter THREADS_PER_BLOCK, default 4, threads per block; power of two, at least 2.
REQ-003 SHALL have parameter THREAD_COUNT_BITS, default 8, width of the kernel thread count and block IDs.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-006 SHALL have port reset  input  1  synchronous active-high reset.
REQ-007 SHALL have port start  input  1  kernel launch request; level-sensitive.
REQ-008 SHALL have port thread_count  input  THREAD_COUNT_BITS  total kernel threads; sampled at launch.
REQ-009 SHALL have port core_done  input  NUM_CORES  per-core block-finished indication.
REQ-010 SHALL have port core_reset  output  NUM_CORES  one-cycle per-core clear before a block.
REQ-011 SHALL have port core_start  output  NUM_CORES  per-core run enable; held high while the block runs.
REQ-012 SHALL have port core_block_id  output  NUM_CORES x THREAD_COUNT_BITS  block index assigned to each core.
REQ-013 SHALL have port core_thread_count  output  NUM_CORES x ($clog2(THREADS_PER_BLOCK)+1)  active threads in the assigned block.
REQ-014 SHALL have port done  output  1  kernel complete.

Function
REQ-015 SHALL implement the top-level FSM states IDLE, DISPATCH and DONE.
REQ-016 In IDLE with start=1: latch thread_count; set total_blocks=ceil(thread_count/THREADS_PER_BLOCK) using a THREAD_COUNT_BITS+1 intermediate; clear blocks_dispatched and blocks_done; enter DISPATCH.
REQ-017 When the latched thread_count=0, SHALL enter DONE on the cycle after DISPATCH entry, with no core_reset or core_start pulses.
REQ-018 SHALL keep a per-core state of FREE, CLEARING or RUNNING; all cores are FREE on DISPATCH entry.
REQ-019 In DISPATCH, each FREE core with blocks_dispatched<total_blocks SHALL go to CLEARING at the next edge: core_reset=1 for exactly one cycle, core_block_id=next id, blocks_dispatched incremented.
REQ-020 When several cores are FREE in one cycle, SHALL assign consecutive ascending block IDs in ascending core index, limited by the blocks remaining; lower cores win.
REQ-021 CLEARING SHALL always advance to RUNNING at the next edge, with core_reset=0 and core_start=1.
REQ-022 core_thread_count SHALL be THREADS_PER_BLOCK, except for the last block when thread_count mod THREADS_PER_BLOCK is nonzero, where it is that remainder.
REQ-023 core_done SHALL be honored only when the core is RUNNING: core_start is cleared, the core goes FREE and blocks_done is incremented at the next edge; otherwise core_done is ignored.
REQ-024 A freed core SHALL become eligible for a new block on the cycle after it goes FREE; freeing and re-dispatching are never combined in one edge.
REQ-025 Simultaneous core_done on several cores SHALL add the number of completing cores to blocks_done in one cycle.
REQ-026 When blocks_done=total_blocks in DISPATCH, SHALL enter DONE at the next edge with done=1 registered.
REQ-027 In DONE, done SHALL stay 1 while start=1; when start=0, SHALL return to IDLE with done=0. start held high in DONE SHALL NOT relaunch the kernel.
REQ-028 Changes to start or thread_count outside IDLE SHALL have no effect.
REQ-029 core_block_id and core_thread_count SHALL hold their last values until the core's next assignment.

Reset
REQ-030 reset=1 at an edge SHALL force, in any state including mid-kernel: IDLE; all cores FREE; core_reset=0; core_start=0; core_block_id=0; core_thread_count=0; done=0; all counters=0.
REQ-031 reset SHALL take priority over start and core_done in the same cycle.

Verification (NUM_CORES=2, THREADS_PER_BLOCK=4)
REQ-032 thread_count=8, start pulse -> cores 0 and 1 get core_reset in the same cycle with ids 0 and 1 and thread counts 4 and 4; core_start follows one cycle later; both core_done -> done=1 the cycle after blocks_done=2.
REQ-033 thread_count=10, core 1 finishes first -> block 2 goes to core 1 with core_thread_count=2; done only after all 3 blocks finish.
REQ-034 thread_count=0 -> done=1 two cycles after start is sampled; no core_reset or core_start activity.
REQ-035 thread_count=16, both core_done in the same cycle -> blocks_done increases by 2; next cycle both cores are re-dispatched with core 0 id=2 and core 1 id=3.
REQ-036 thread_count=255 -> 64 blocks dispatched; last id 63 with core_thread_count=3; done=1; start=0 -> IDLE with done=0.
REQ-037 reset asserted mid-run while both cores are RUNNING -> next cycle all outputs are 0; stray core_done is ignored; a new start relaunches from block 0.
